mult_seq: RTL

//  Parametrised iterative shift-add multiplier producing full 2*WIDTH-bit product
//  as HI/LO halves. Per-operation SIGNED/unsigned mode select.
//  One product bit per cycle; start/done handshake.

---
 rtl/mult_seq_pkg.sv | 18 +
 rtl/mult_seq_dp.sv | 65 ++++++
 rtl/mult_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_seq_pkg : shared constants and FSM encoding for the sequential multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
package mult_seq_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2
    } state_e;

endpackage : mult_seq_pkg
`default_nettype wire

// File: rtl/mult_seq_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_seq_dp : operand magnitudes, shift-add accumulator and final sign fix
// Rev 1.0
// ---------------------------------------------------------------------------
module mult_seq_dp
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             fin_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0]   mcnd_q, mplr_q, acc_q, hi_q, lo_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag_d, b_mag_d, addend_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] prod_d, res_d;

    // The most-negative value negates to itself, which is its exact unsigned magnitude.
    assign a_mag_d  = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
    assign b_mag_d  = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
    assign addend_d = mplr_q[0] ? mcnd_q : '0;
    assign sum_d    = {1'b0, acc_q} + {1'b0, addend_d};
    assign prod_d   = {acc_q, mplr_q};
    assign res_d    = neg_q ? (~prod_d + (2*WIDTH)'(1)) : prod_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcnd_q <= '0;
            mplr_q <= '0;
            acc_q  <= '0;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (load_i) begin
                mcnd_q <= a_mag_d;
                mplr_q <= b_mag_d;
                acc_q  <= '0;
                neg_q  <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            end else if (step_i) begin
                // Carry out of the adder becomes the new accumulator MSB.
                {acc_q, mplr_q} <= {sum_d, mplr_q[WIDTH-1:1]};
            end
            if (fin_i) begin
                {hi_q, lo_q} <= res_d;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule : mult_seq_dp
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_seq : iterative shift-add multiplier, FSM/counter/handshake wrapper
// Rev 1.0
// ---------------------------------------------------------------------------
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic             load_d, step_d, fin_d;

    assign load_d = (state_q == ST_IDLE) && start_i;
    assign step_d = (state_q == ST_RUN);
    assign fin_d  = (state_q == ST_SIGN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= start_i;
                    cnt_q  <= '0;
                    if (start_i) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_SIGN;
                end
                ST_SIGN: begin
                    // BUSY stays up through the DONE cycle; IDLE decides whether it drops.
                    busy_q  <= 1'b1;
                    done_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    mult_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (load_d),
        .step_i   (step_d),
        .fin_i    (fin_d),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule : mult_seq
`default_nettype wire
